// File: rtl/alu_dispatch_pkg.sv
// Shared types for the ALU dispatcher: instruction layout, opcodes, FSM states
// and the opcode-to-enable-hold table.
package alu_dispatch_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 16;
    localparam int unsigned SRF_W  = 3;
    localparam int unsigned HOLD_W = 3;

    // Field order fixes the bit positions of the 24-bit instruction word.
    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [SRF_W-1:0]  srf;
        logic              use_carry;
        logic              dec;
        logic              rsvd;
    } instr_t;

    localparam int unsigned INSTR_W = $bits(instr_t);

    localparam logic [OP_W-1:0] OP_TST    = 6'b000110;
    localparam logic [OP_W-1:0] OP_SHL    = 6'b100100;
    localparam logic [OP_W-1:0] OP_CMP    = 6'b010110;
    localparam logic [OP_W-1:0] OP_INCDEC = 6'b010000;
    localparam logic [OP_W-1:0] OP_ADD    = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB    = 6'b100001;
    localparam logic [OP_W-1:0] OP_MUL    = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND    = 6'b100011;
    localparam logic [OP_W-1:0] OP_OR     = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR    = 6'b010010;
    localparam logic [OP_W-1:0] OP_NOT    = 6'b010011;
    localparam logic [OP_W-1:0] OP_SHR    = 6'b010100;
    localparam logic [OP_W-1:0] OP_ROT    = 6'b010101;
    localparam logic [OP_W-1:0] OP_MOV    = 6'b011101;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_READ,
        ST_ISSUE,
        ST_WAIT,
        ST_WB
    } state_e;

    typedef struct packed {
        logic              legal;
        logic [HOLD_W-1:0] hold;
    } hold_info_t;

    // Number of cycles the ALU enable must stay high for each opcode.
    function automatic hold_info_t hold_lookup(input logic [OP_W-1:0] op);
        hold_info_t info;
        info = '0;
        case (op)
            OP_TST, OP_SHL, OP_CMP, OP_INCDEC:
                info = '{legal: 1'b1, hold: HOLD_W'(2)};
            OP_ADD, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHR, OP_ROT, OP_MOV:
                info = '{legal: 1'b1, hold: HOLD_W'(3)};
            OP_SUB:
                info = '{legal: 1'b1, hold: HOLD_W'(4)};
            default:
                info = '0;
        endcase
        return info;
    endfunction

    // Compare/test only update flags.
    function automatic logic writes_rf(input logic [OP_W-1:0] op);
        return !((op == OP_CMP) || (op == OP_TST));
    endfunction

endpackage

// File: rtl/alu_hold_lut.sv
// Opcode decode: legality and ALU enable hold length.
module alu_hold_lut
    import alu_dispatch_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    output logic              legal_c,
    output logic [HOLD_W-1:0] hold_c
);

    hold_info_t info_c;

    always_comb begin
        info_c = hold_lookup(opcode);
    end

    assign legal_c = info_c.legal;
    assign hold_c  = info_c.hold;

endmodule

// File: rtl/alu_dispatch.sv
// Single-issue dispatcher: reads two registers, drives a multi-cycle ALU for a
// per-opcode number of enable cycles, then writes back result and flags.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int unsigned NREG      = 16,
    parameter int unsigned FLUSH_CYC = 4
) (
    input  logic                wire_clock,
    input  logic                wire_reset_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr,
    output logic [REG_AW-1:0]   rf_raddr_a,
    output logic [REG_AW-1:0]   rf_raddr_b,
    input  logic [DATA_W-1:0]   rf_rdata_a,
    input  logic [DATA_W-1:0]   rf_rdata_b,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                enable_alu,
    output logic [DATA_W-1:0]   m3,
    output logic [DATA_W-1:0]   m4,
    output logic [OP_W-1:0]     opCode,
    output logic [FLAG_W-1:0]   FR_in,
    output logic                useCarry,
    output logic [SRF_W-1:0]    flagToShifthAndRot,
    output logic                dec,
    input  logic [DATA_W-1:0]   m2,
    input  logic [FLAG_W-1:0]   FR_out,
    output logic [FLAG_W-1:0]   fr_q,
    output logic                busy,
    output logic                illegal_op
);

    localparam int unsigned FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_e              state_q, state_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    instr_t              instr_q, instr_d;
    logic [DATA_W-1:0]   m3_q, m3_d, m4_q, m4_d;
    logic [OP_W-1:0]     opcode_q, opcode_d;
    logic [FLAG_W-1:0]   fr_in_q, fr_in_d, fr_d;
    logic                use_carry_q, use_carry_d, dec_q, dec_d;
    logic [SRF_W-1:0]    srf_q, srf_d;
    logic                enable_q, enable_d, rf_we_q, rf_we_d;
    logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic                instr_ready_q, instr_ready_d, busy_q, busy_d;
    logic                illegal_q, illegal_d;
    logic                lut_legal_c;
    logic [HOLD_W-1:0]   lut_hold_c;
    logic                unused_c;

    alu_hold_lut u_hold_lut (
        .opcode  (instr_q.opcode),
        .legal_c (lut_legal_c),
        .hold_c  (lut_hold_c)
    );

    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            state_q       <= ST_FLUSH;
            flush_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            instr_q       <= '0;
            m3_q          <= '0;
            m4_q          <= '0;
            opcode_q      <= '0;
            fr_in_q       <= '0;
            use_carry_q   <= 1'b0;
            dec_q         <= 1'b0;
            srf_q         <= '0;
            fr_q          <= '0;
            enable_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            instr_q       <= instr_d;
            m3_q          <= m3_d;
            m4_q          <= m4_d;
            opcode_q      <= opcode_d;
            fr_in_q       <= fr_in_d;
            use_carry_q   <= use_carry_d;
            dec_q         <= dec_d;
            srf_q         <= srf_d;
            fr_q          <= fr_d;
            enable_q      <= enable_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            illegal_q     <= illegal_d;
        end
    end

    // Next state; registered outputs are decoded from the next state so they
    // line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        instr_d     = instr_q;
        m3_d        = m3_q;
        m4_d        = m4_q;
        opcode_d    = opcode_q;
        fr_in_d     = fr_in_q;
        use_carry_d = use_carry_q;
        dec_d       = dec_q;
        srf_d       = srf_q;
        fr_d        = fr_q;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        illegal_d   = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_W'(FLUSH_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr_t'(instr);
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                m3_d        = rf_rdata_a;
                m4_d        = rf_rdata_b;
                opcode_d    = instr_q.opcode;
                use_carry_d = instr_q.use_carry;
                dec_d       = instr_q.dec;
                srf_d       = instr_q.srf;
                fr_in_d     = fr_q;
                if (lut_legal_c) begin
                    hold_cnt_d = lut_hold_c - HOLD_W'(1);
                    state_d    = ST_ISSUE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (hold_cnt_q == '0) begin
                    rf_waddr_d = instr_q.rd;
                    rf_wdata_d = m2;
                    state_d    = ST_WB;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    state_d    = ST_WAIT;
                end
            end
            ST_WB: begin
                fr_d    = FR_out;
                state_d = ST_IDLE;
            end
            default: state_d = ST_FLUSH;
        endcase

        instr_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        enable_d      = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        rf_we_d       = (state_d == ST_WB) && writes_rf(opcode_q)
                        && (32'(instr_q.rd) < NREG);
    end

    assign unused_c           = instr_q.rsvd;
    assign instr_ready        = instr_ready_q;
    assign rf_raddr_a         = instr_q.ra;
    assign rf_raddr_b         = instr_q.rb;
    assign rf_we              = rf_we_q;
    assign rf_waddr           = rf_waddr_q;
    assign rf_wdata           = rf_wdata_q;
    assign enable_alu         = enable_q;
    assign m3                 = m3_q;
    assign m4                 = m4_q;
    assign opCode             = opcode_q;
    assign FR_in              = fr_in_q;
    assign useCarry           = use_carry_q;
    assign flagToShifthAndRot = srf_q;
    assign dec                = dec_q;
    assign busy               = busy_q;
    assign illegal_op         = illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural register file and ALU stub.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [23:0] instr;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic        enable_alu;
    logic [31:0] m3, m4, m2;
    logic [5:0]  opCode;
    logic [15:0] FR_in, FR_out, fr_q;
    logic        useCarry, dec_bit, busy, illegal_op;
    logic [2:0]  flagToShifthAndRot;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_dispatch dut (
        .wire_clock         (clk),
        .wire_reset_n       (rst_n),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr              (instr),
        .rf_raddr_a         (rf_raddr_a),
        .rf_raddr_b         (rf_raddr_b),
        .rf_rdata_a         (rf_rdata_a),
        .rf_rdata_b         (rf_rdata_b),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .enable_alu         (enable_alu),
        .m3                 (m3),
        .m4                 (m4),
        .opCode             (opCode),
        .FR_in              (FR_in),
        .useCarry           (useCarry),
        .flagToShifthAndRot (flagToShifthAndRot),
        .dec                (dec_bit),
        .m2                 (m2),
        .FR_out             (FR_out),
        .fr_q               (fr_q),
        .busy               (busy),
        .illegal_op         (illegal_op)
    );

    // Register file: asynchronous read, synchronous write; presets share the port.
    logic [31:0] rf [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    always @(posedge clk) begin
        if (pre_we)     rf[pre_addr] <= pre_data;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    // ALU stub with hand-chosen flag outputs.
    always_comb begin
        m2     = m3 ^ m4;
        FR_out = 16'h0000;
        case (opCode)
            6'b100000: begin m2 = m3 + m4; FR_out = 16'h0020; end
            6'b100001: begin
                m2     = (m3 >= m4) ? (m3 - m4) : 32'h0;
                FR_out = (m3 < m4) ? 16'h0040 : 16'h0000;
            end
            6'b010110: begin m2 = 32'h0; FR_out = {m3 < m4, m3 > m4, m3 == m4, 13'b0}; end
            6'b010000: m2 = dec_bit ? (m3 - 32'd1) : (m3 + 32'd1);
            6'b100010: m2 = m3 * m4;
            default: ;
        endcase
    end

    // Activity monitor sampled on the falling edge.
    int run = 0, last_run = 0, runs = 0, gap = 0, min_gap = 99, we_cnt = 0, ill_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
            gap = 0;
        end else if (enable_alu) begin
            if (run == 0) begin
                runs++;
                if (gap < min_gap) min_gap = gap;
            end
            run++;
            gap = 0;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
            gap++;
        end
        if (rf_we) we_cnt++;
        if (illegal_op) ill_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic [5:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic d);
        return {op, rd, ra, rb, 3'b000, 1'b0, d, 1'b0};
    endfunction

    task automatic preset(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Called at the negedge just after acceptance; returns the cycle index of rf_we.
    task automatic wait_done(output int lat);
        int n;
        lat = 0;
        n   = 1;
        while (!instr_ready && n < 40) begin
            if (rf_we && lat == 0) lat = n;
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check_eq("done_timeout", 32'(instr_ready), 32'd1);
        #1;
    endtask

    task automatic run_instr(input logic [23:0] w, output int lat);
        int n;
        n = 0;
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check_eq("ready_timeout", 32'(instr_ready), 32'd1);
        instr = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int lat, we0, ill0, runs0;
        bit any_rdy, any_en;

        rst_n = 1'b0;
        instr_valid = 1'b1;
        instr = mk(6'b100000, 4'd3, 4'd1, 4'd2, 1'b0);
        preset(4'd1, 32'd5);
        preset(4'd2, 32'd7);
        preset(4'd3, 32'hFFFF_FFFF);
        #1;
        check_eq("rst_enable", 32'(enable_alu), 32'd0);
        check_eq("rst_rf_we", 32'(rf_we), 32'd0);
        check_eq("rst_ready", 32'(instr_ready), 32'd0);
        check_eq("rst_illegal", 32'(illegal_op), 32'd0);
        check_eq("rst_fr_q", 32'(fr_q), 32'd0);
        check_eq("rst_m3_opcode", {m3[25:0], opCode}, 32'd0);

        // Flush window with instr_valid held high.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        any_rdy = instr_ready;
        any_en  = enable_alu;
        repeat (3) begin
            @(negedge clk);
            any_rdy |= instr_ready;
            any_en  |= enable_alu;
        end
        check_eq("flush_ready_low", 32'(any_rdy), 32'd0);
        @(negedge clk);
        check_eq("flush_ready_high", 32'(instr_ready), 32'd1);
        check_eq("flush_enable_low", 32'(any_en), 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        wait_done(lat);
        check_eq("add_result", rf[3], 32'h0000_000C);
        check_eq("add_hold", 32'(last_run), 32'd3);
        check_eq("add_latency", 32'(lat), 32'd5);
        check_eq("add_fr", 32'(fr_q), 32'h0020);
        check_eq("add_m3_held", m3, 32'd5);

        // SUB with borrow
        preset(4'd1, 32'd3);
        preset(4'd2, 32'd9);
        preset(4'd4, 32'hDEAD);
        run_instr(mk(6'b100001, 4'd4, 4'd1, 4'd2, 1'b0), lat);
        check_eq("sub_result", rf[4], 32'd0);
        check_eq("sub_hold", 32'(last_run), 32'd4);
        check_eq("sub_latency", 32'(lat), 32'd6);
        check_eq("sub_fr6", 32'(fr_q[6]), 32'd1);

        // CMP equal: flags only
        preset(4'd5, 32'd4);
        preset(4'd6, 32'd4);
        preset(4'd7, 32'h1234);
        we0 = we_cnt;
        run_instr(mk(6'b010110, 4'd7, 4'd5, 4'd6, 1'b0), lat);
        check_eq("cmp_no_write", 32'(we_cnt - we0), 32'd0);
        check_eq("cmp_fr", 32'(fr_q[15:13]), 32'd1);
        check_eq("cmp_rd_kept", rf[7], 32'h1234);
        check_eq("cmp_hold", 32'(last_run), 32'd2);

        // Illegal opcode
        we0 = we_cnt; ill0 = ill_cnt; runs0 = runs;
        run_instr(mk(6'b111111, 4'd1, 4'd1, 4'd2, 1'b0), lat);
        @(negedge clk);
        check_eq("ill_pulse", 32'(ill_cnt - ill0), 32'd1);
        check_eq("ill_no_write", 32'(we_cnt - we0), 32'd0);
        check_eq("ill_no_enable", 32'(runs - runs0), 32'd0);
        check_eq("ill_fr_kept", 32'(fr_q), 32'h2000);
        check_eq("ill_rf_kept", rf[1], 32'd3);

        // Reset during WAIT of a MUL
        preset(4'd8, 32'd6);
        preset(4'd9, 32'd7);
        preset(4'd10, 32'hAAAA);
        we0 = we_cnt;
        instr = mk(6'b100010, 4'd10, 4'd8, 4'd9, 1'b0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mul_enable_on", 32'(enable_alu), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mul_rst_enable", 32'(enable_alu), 32'd0);
        check_eq("mul_rst_we", 32'(rf_we), 32'd0);
        check_eq("mul_rst_fr", 32'(fr_q), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("mul_no_write", 32'(we_cnt - we0), 32'd0);
        check_eq("mul_rd_kept", rf[10], 32'hAAAA);
        rst_n = 1'b1;

        // Back-to-back INC/DEC on r0
        preset(4'd0, 32'h0000_FFFF);
        min_gap = 99;
        run_instr(mk(6'b010000, 4'd0, 4'd0, 4'd0, 1'b0), lat);
        check_eq("inc_result", rf[0], 32'h0001_0000);
        run_instr(mk(6'b010000, 4'd0, 4'd0, 4'd0, 1'b1), lat);
        check_eq("dec_result", rf[0], 32'h0000_FFFF);
        check_eq("dec_hold", 32'(last_run), 32'd2);
        check_eq("enable_gap_ge2", 32'(min_gap >= 2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have parameter NREG, default 16, giving the register-file depth. Register addresses are 4 bits.
REQ-002 SHALL have parameter FLUSH_CYC, default 4, giving the number of cycles enable_alu is held low after reset before the first issue.
REQ-003 wire_clock  in  1  sole clock; all logic on posedge.
REQ-004 wire_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_ready  out  1  dispatcher can accept an instruction.
REQ-007 instr  in  24  instruction word:
- [23:18] opcode
- [17:14] rd
- [13:10] ra
- [9:6] rb
- [5:3] shift/rot flags
- [2] use carry
- [1] dec
- [0] reserved
REQ-008 rf_raddr_a, rf_raddr_b  out  4  register-file read addresses; read data arrives one cycle later.
REQ-009 rf_rdata_a, rf_rdata_b  in  32  register-file read data.
REQ-010 rf_we  out  1 / rf_waddr  out  4 / rf_wdata  out  32  register-file synchronous write port.
REQ-011 enable_alu, m3, m4, opCode, FR_in, useCarry, flagToShifthAndRot, dec  out  1/32/32/6/16/1/3/1  ALU operand side.
REQ-012 m2  in  32 / FR_out  in  16  ALU results.
REQ-013 fr_q  out  16  architectural flag register.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 illegal_op  out  1  one-cycle pulse on an unknown opcode.

Function
REQ-016 SHALL implement an FSM with states FLUSH, IDLE, READ, ISSUE, WAIT, WB.
REQ-017 instr_ready SHALL be 1 only in IDLE. A transfer occurs on instr_valid&&instr_ready at posedge; the instruction is latched, rf_raddr_a=ra and rf_raddr_b=rb are driven, and the FSM goes to READ.
REQ-018 READ SHALL latch m3=rf_rdata_a, m4=rf_rdata_b, opCode, useCarry, dec, flagToShifthAndRot and FR_in=fr_q, then go to ISSUE.
REQ-019 m3, m4, opCode, FR_in and the control bits SHALL remain stable from ISSUE through WB.
REQ-020 ISSUE/WAIT SHALL hold enable_alu=1 for exactly HOLD consecutive cycles, then deassert:
- HOLD=2 for opcodes 000110, 100100, 010110, 010000
- HOLD=3 for 100000, 100010, 100011, 100101, 010010, 010011, 010100, 010101, 011101
- HOLD=4 for 100001
REQ-021 WB SHALL have enable_alu=0. In WB:
- fr_q <= FR_out
- for opcodes other than 010110 and 000110: rf_we=1, rf_waddr=rd, rf_wdata=m2
REQ-022 After WB the FSM SHALL return to IDLE. enable_alu is therefore low for at least 2 cycles between issues, guaranteeing a fresh rising edge at the ALU.
REQ-023 Latency from accept to write SHALL be HOLD+2 cycles. Throughput SHALL be one instruction per HOLD+3 cycles.
REQ-024 An unknown opcode SHALL:
- skip ISSUE/WAIT/WB
- pulse illegal_op in READ's following cycle
- leave fr_q and the register file unchanged
- return to IDLE
REQ-025 rf_we SHALL be 0 in every state except WB.
REQ-026 instr_valid while instr_ready=0 SHALL be ignored; the upstream source holds the instruction.
REQ-027 rd==ra or rd==rb SHALL be legal. The write occurs in WB, after operands were latched in READ.

Reset
REQ-028 Asserting wire_reset_n=0 SHALL immediately drive:
- enable_alu=0, rf_we=0, illegal_op=0, instr_ready=0
- fr_q=16'h0000, m3=m4=0, opCode=0, FR_in=0
- state=FLUSH
REQ-029 Reset mid-operation SHALL abort the operation with no register-file write.
REQ-030 FLUSH SHALL last FLUSH_CYC cycles after reset release with enable_alu=0, allowing the unreset ALU stage counter to settle, then go to IDLE.

Structure
REQ-031 The following SHALL live in the shared package:
- opcode constants
- instruction field positions
- the opcode-to-HOLD table
- FSM state encoding
REQ-032 A single sub-module, alu_hold_lut (opcode -> HOLD, legal bit), SHALL implement the table. No other sub-modules are used.

Verification
REQ-033 Reset release: instr_valid=1 throughout. instr_ready SHALL stay 0 for 4 cycles, then 1. enable_alu SHALL never be 1 during FLUSH.
REQ-034 ADD: r1=5, r2=7, opcode 100000, rd=r3. enable_alu SHALL be high exactly 3 cycles. r3 SHALL be written 32'h0000000C, and fr_q SHALL equal FR_out in WB.
REQ-035 SUB: opcode 100001, r1=3, r2=9. enable_alu SHALL be high exactly 4 cycles; FR_out[6]=1 SHALL be captured into fr_q; rd SHALL be written 0.
REQ-036 CMP: opcode 010110, r1=r2=4. rf_we SHALL never assert; fr_q[15:13] SHALL become 3'b001.
REQ-037 Back-to-back: INC r0 (dec=0, r0=FFFF) then DEC r0. Sequence required:
- enable_alu low ≥2 cycles between the two instructions
- r0=32'h00010000 after the first
- r0=32'h0000FFFF after the second
REQ-038 Illegal opcode 111111: illegal_op SHALL pulse once; enable_alu and rf_we SHALL stay 0. Reset asserted during WAIT of a MUL: enable_alu SHALL drop immediately and no write SHALL occur.
